// File: rtl/ntt_seq.sv
// Sequential N-point NTT over Z_q with one modular multiply-accumulate per cycle.
// Coefficients stream in, X[i] = sum_j x[j]*w^(i*j) mod q streams out.
module ntt_seq #(
   parameter int N  = 8,
   parameter int W  = 4,
   parameter int QW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [QW-1:0] q,
   input  logic [QW-1:0] w,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] out_data,
   output logic          busy
);

   localparam int CW = $clog2(N);
   localparam int PW = 2 * QW;
   localparam int SW = 2 * QW + 1;
   localparam int IW = (W > QW) ? W : QW;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [QW-1:0] ONE  = QW'(1);

   typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] idx_q, idx_d, k_q, k_d;
   logic [CW-1:0] i_q, i_d, j_q, j_d;
   logic [QW-1:0] acc_q, acc_d, step_q, step_d, twid_q, twid_d;
   logic [QW-1:0] qs_q, qs_d, ws_q, ws_d;
   logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic [QW-1:0] out_data_q, out_data_d;

   logic [QW-1:0] x_q   [N];
   logic [QW-1:0] res_q [N];
   logic          x_we, res_we;

   logic [QW-1:0] q_eff, in_red, mac, twid_n, step_n;
   logic [PW-1:0] prod;

   // the frame's first coefficient is reduced by the modulus being latched with it
   assign q_eff  = (idx_q == '0) ? q : qs_q;
   assign in_red = QW'(IW'(in_data) % IW'(q_eff));
   assign prod   = PW'(x_q[j_q]) * PW'(twid_q);
   assign mac    = QW'((SW'(acc_q) + SW'(prod)) % SW'(qs_q));
   assign twid_n = QW'((PW'(twid_q) * PW'(step_q)) % PW'(qs_q));
   assign step_n = QW'((PW'(step_q) * PW'(ws_q)) % PW'(qs_q));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      k_d         = k_q;
      i_d         = i_q;
      j_d         = j_q;
      acc_d       = acc_q;
      step_d      = step_q;
      twid_d      = twid_q;
      qs_d        = qs_q;
      ws_d        = ws_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      out_data_d  = out_data_q;
      x_we        = 1'b0;
      res_we      = 1'b0;
      unique case (state_q)
         LOAD: begin
            if (in_valid && in_ready_q) begin
               x_we = 1'b1;
               if (idx_q == '0) begin
                  qs_d = q;
                  ws_d = w;
               end
               if (idx_q == LAST) begin
                  idx_d      = '0;
                  state_d    = COMPUTE;
                  in_ready_d = 1'b0;
                  busy_d     = 1'b1;
                  i_d        = '0;
                  j_d        = '0;
                  acc_d      = '0;
                  step_d     = ONE;
                  twid_d     = ONE;
               end else begin
                  idx_d = idx_q + CW'(1);
               end
            end
         end
         COMPUTE: begin
            twid_d = twid_n;
            if (j_q == LAST) begin
               res_we = 1'b1;
               acc_d  = '0;
               twid_d = ONE;
               step_d = step_n;
               j_d    = '0;
               if (i_q == LAST) begin
                  i_d         = '0;
                  k_d         = '0;
                  state_d     = OUTPUT;
                  out_valid_d = 1'b1;
                  out_data_d  = res_q[0];
               end else begin
                  i_d = i_q + CW'(1);
               end
            end else begin
               acc_d = mac;
               j_d   = j_q + CW'(1);
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               if (k_q == LAST) begin
                  k_d         = '0;
                  state_d     = LOAD;
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  in_ready_d  = 1'b1;
               end else begin
                  k_d        = k_q + CW'(1);
                  out_data_d = res_q[k_q + CW'(1)];
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         idx_q       <= '0;
         k_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         acc_q       <= '0;
         step_q      <= ONE;
         twid_q      <= ONE;
         qs_q        <= '0;
         ws_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         k_q         <= k_d;
         i_q         <= i_d;
         j_q         <= j_d;
         acc_q       <= acc_d;
         step_q      <= step_d;
         twid_q      <= twid_d;
         qs_q        <= qs_d;
         ws_q        <= ws_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         out_data_q  <= out_data_d;
      end
   end

   // buffers hold data across reset; the FSM never reads stale entries
   always_ff @(posedge clk) begin
      if (rst_n && x_we)   x_q[idx_q] <= in_red;
      if (rst_n && res_we) res_q[i_q] <= mac;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_ntt_seq.sv
// Directed checks for ntt_seq: known 8-point transforms mod 17,
// input reduction, backpressure, q/w sampling and mid-frame reset.
module tb_ntt_seq;

   typedef logic [3:0] vin_t  [8];
   typedef logic [7:0] vout_t [8];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] q = 8'd17;
   logic [7:0] w = 8'd2;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       busy;

   int tests = 0;
   int fails = 0;

   ntt_seq #(.N(8), .W(4), .QW(8)) dut (
      .clk(clk), .rst_n(rst_n), .q(q), .w(w),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] qv, input logic [7:0] wv,
                             input vin_t xs, input bit gaps, input bit chg);
      int n = 0;
      int cyc = 0;
      while (n < 8 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = xs[n];
            q = qv;
            w = wv;
            if (chg && n > 0) begin
               q = 8'd5;
               w = 8'd3;
            end
            if (in_ready) n++;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("send_done", n, 8);
   endtask

   task automatic recv_frame(input string tag, input vout_t exp, input bit tog);
      int c = 0;
      int k = 0;
      int cyc = 0;
      while (c < 200) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            check("busy_compute", busy, 1);
            check("in_ready_compute", in_ready, 0);
         end
         if (out_valid) break;
      end
      check({tag, "_latency"}, c, 65);
      while (k < 8 && cyc < 400) begin
         check({tag, "_data"}, out_data, exp[k]);
         check("in_ready_out", in_ready, 0);
         out_ready = tog ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk);
         if (out_ready) k++;
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      check({tag, "_count"}, k, 8);
      check("in_ready_after", in_ready, 1);
      check("out_valid_after", out_valid, 0);
      check("busy_after", busy, 0);
   endtask

   vin_t  x_imp  = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
   vin_t  x_sh   = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
   vin_t  x_ones = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
   vin_t  x_15   = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
   vin_t  x_two  = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
   vout_t e_imp  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
   vout_t e_sh   = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
   vout_t e_ones = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
   vout_t e_two  = '{8'd2, 8'd3, 8'd5, 8'd9, 8'd0, 8'd16, 8'd14, 8'd10};

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      rst_n = 1'b1;

      send_frame(8'd17, 8'd2, x_imp, 1'b0, 1'b0);
      recv_frame("impulse", e_imp, 1'b0);
      send_frame(8'd17, 8'd2, x_sh, 1'b0, 1'b0);
      recv_frame("shift", e_sh, 1'b0);
      send_frame(8'd17, 8'd2, x_ones, 1'b0, 1'b0);
      recv_frame("ones", e_ones, 1'b0);
      send_frame(8'd7, 8'd1, x_15, 1'b0, 1'b0);
      recv_frame("reduce", e_imp, 1'b0);
      send_frame(8'd17, 8'd2, x_two, 1'b0, 1'b0);
      recv_frame("two", e_two, 1'b0);
      send_frame(8'd17, 8'd2, x_sh, 1'b1, 1'b0);
      recv_frame("stall", e_sh, 1'b1);
      send_frame(8'd17, 8'd2, x_sh, 1'b0, 1'b1);
      recv_frame("sample", e_sh, 1'b0);

      send_frame(8'd17, 8'd2, x_ones, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      send_frame(8'd17, 8'd2, x_sh, 1'b0, 1'b0);
      recv_frame("fresh", e_sh, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
